// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, runs one-outstanding fetches over a
// grant/response handshake, and presents the instruction (plus raw immediates) to decode.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [4:0]  iimm_shamt,
  output logic [11:0] iimm,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e      state, state_next;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        sk_valid;
  logic [31:0] sk_pc;
  logic [31:0] sk_instr;

  logic        grant;
  logic        resp;
  logic        slot_free;
  logic        skid_load;
  logic [31:0] target_pc;
  logic [1:0]  unused_redirect_lsbs;

  assign target_pc            = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = redirect_pc[1:0];
  assign imem_addr            = pc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no path infers a latch.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    grant      = 1'b0;
    resp       = 1'b0;
    unique case (state)
      IDLE: begin
        imem_req = !sk_valid && !redirect && !rst;
        grant    = imem_req && imem_gnt;
        if (grant) state_next = WAIT;
      end
      WAIT: begin
        // A response coinciding with a redirect belongs to the old stream and is discarded.
        resp = imem_rvalid && !redirect;
        if (imem_rvalid)   state_next = IDLE;
        else if (redirect) state_next = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target_pc;
    end else if (grant) begin
      req_pc <= pc;
      pc     <= pc + 32'd4;
    end
  end

  // The slot can accept new data when it is empty or being retired this edge.
  assign slot_free = !id_valid || !stall;
  // A response parks in the skid when the slot is held, or when the skid is draining first.
  assign skid_load = resp && (sk_valid || !slot_free);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
      id_instr <= NOP_INSTR;
      sk_valid <= 1'b0;
    end else if (redirect) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      sk_valid <= 1'b0;
    end else begin
      if (slot_free) begin
        if (sk_valid) begin
          id_valid <= 1'b1;
          id_pc    <= sk_pc;
          id_instr <= sk_instr;
        end else if (resp) begin
          id_valid <= 1'b1;
          id_pc    <= req_pc;
          id_instr <= imem_rdata;
        end else if (id_valid) begin
          id_valid <= 1'b0;
          id_instr <= NOP_INSTR;
        end
      end
      if (skid_load)      sk_valid <= 1'b1;
      else if (slot_free) sk_valid <= 1'b0;
    end
  end

  // NOTE: the skid payload has no reset; sk_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      sk_pc    <= req_pc;
      sk_instr <= imem_rdata;
    end
  end

  assign iimm_shamt = id_instr[24:20];
  assign iimm       = id_instr[31:20];
  assign simm       = {id_instr[31:25], id_instr[11:7]};
  assign bimm       = {id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8]};
  assign uimm       = id_instr[31:12];
  assign jimm       = {id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21]};

endmodule
